mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data RAM between the CPU data port (port 0) and the debug/program-loader port (port 1). It accepts at most one command per cycle, drives the RAM directly, and routes the 1-cycle-latency read data back to the port that issued the read. It sits between the CPU's `mem_addr`/`mem_data_write`/`mem_write_enabled` outputs and the RAM, and lets the RAM be loaded or inspected while the CPU runs.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-RAM arbiter bus: two requester ports plus the single-port RAM side.
// The arbiter takes the slave view; requesters and RAM take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM (CPU port 0, debug port 1).
// One command per cycle; 1-cycle read data is steered back to the issuing port.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int CPU_PRIORITY = 1,
    parameter int MAX_WAIT     = 8
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic             last;
    logic [CNT_W-1:0] wait_cnt;
    logic             rd_pend_v;
    logic             rd_pend_id;
    logic             boost;
    logic             tie_sel1;
    logic             g0, g1;
    logic             mux_we;

    always_comb begin
        boost    = (MAX_WAIT != 0) && (CPU_PRIORITY != 0) && (wait_cnt == CNT_W'(MAX_WAIT));
        tie_sel1 = (CPU_PRIORITY != 0) ? boost : ~last;
        g0 = 1'b0;
        g1 = 1'b0;
        // Reset blocks grants combinationally so nothing reaches the RAM while it is held.
        if (!rst) begin
            if (bus.req0 && bus.req1) begin
                g1 = tie_sel1;
                g0 = ~tie_sel1;
            end else begin
                g0 = bus.req0;
                g1 = bus.req1;
            end
        end
    end

    always_comb begin
        mux_we        = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (g0) begin
            mux_we        = bus.we0;
            bus.ram_addr  = bus.addr0;
            bus.ram_wdata = bus.wdata0;
        end else if (g1) begin
            mux_we        = bus.we1;
            bus.ram_addr  = bus.addr1;
            bus.ram_wdata = bus.wdata1;
        end
    end

    assign bus.gnt0   = g0;
    assign bus.gnt1   = g1;
    assign bus.ram_en = g0 | g1;
    assign bus.ram_we = mux_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= 1'b1;
            wait_cnt   <= '0;
            rd_pend_v  <= 1'b0;
            rd_pend_id <= 1'b0;
        end else begin
            if (g0 | g1) last <= g1;
            rd_pend_v  <= (g0 | g1) & ~mux_we;
            rd_pend_id <= g1;
            if (CPU_PRIORITY == 0 || !bus.req1 || g1)
                wait_cnt <= '0;
            else if (wait_cnt != CNT_W'(MAX_WAIT))
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Masking with rst drops a read whose data would land during a reset cycle.
    assign bus.rvalid0 = rd_pend_v & ~rd_pend_id & ~rst;
    assign bus.rvalid1 = rd_pend_v &  rd_pend_id & ~rst;
    assign bus.rdata0  = bus.rvalid0 ? bus.ram_rdata : '0;
    assign bus.rdata1  = bus.rvalid1 ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations (priority+boost 3, round-robin, priority no boost)
// driven by one stimulus stream and checked against a transaction-level model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;

    logic        o_gnt0[3], o_gnt1[3], o_rv0[3], o_rv1[3], o_en[3], o_we[3];
    logic [15:0] o_addr[3], o_wd[3], o_rd0[3], o_rd1[3];

    int n_assert = 0;
    int n_fail   = 0;

    // model state per configuration
    bit          m_last[3];
    int          m_wcnt[3];
    bit          m_pv[3], m_pid[3];
    logic [15:0] m_pdata[3];
    bit   [15:0] m_mem[3][256];

    always #5 clk = ~clk;

    for (genvar c = 0; c < 3; c++) begin : g
        localparam int PRIO = (c == 1) ? 0 : 1;
        localparam int MW   = (c == 2) ? 0 : 3;
        bit [15:0] ram [256];

        mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
        mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_PRIORITY(PRIO), .MAX_WAIT(MW)) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );

        assign bus.req0 = req0;    assign bus.req1 = req1;
        assign bus.we0 = we0;      assign bus.we1 = we1;
        assign bus.addr0 = addr0;  assign bus.addr1 = addr1;
        assign bus.wdata0 = wdata0; assign bus.wdata1 = wdata1;

        always @(posedge clk) begin
            if (bus.ram_en && bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
            if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= ram[bus.ram_addr[7:0]];
        end

        assign o_gnt0[c] = bus.gnt0;    assign o_gnt1[c] = bus.gnt1;
        assign o_rv0[c]  = bus.rvalid0; assign o_rv1[c]  = bus.rvalid1;
        assign o_en[c]   = bus.ram_en;  assign o_we[c]   = bus.ram_we;
        assign o_addr[c] = bus.ram_addr; assign o_wd[c]  = bus.ram_wdata;
        assign o_rd0[c]  = bus.rdata0;  assign o_rd1[c]  = bus.rdata1;
    end

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cfg%0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                         input bit r1, input bit w1, input logic [15:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    // Check one cycle at the falling edge, advance the model, then step past the next rising edge.
    task automatic cycle();
        @(negedge clk);
        chk("wait_cnt", 0, 32'(g[0].dut.wait_cnt), 32'(m_wcnt[0]));
        for (int c = 0; c < 3; c++) begin
            int prio = (c == 1) ? 0 : 1;
            int mw   = (c == 2) ? 0 : 3;
            bit boost, e0, e1, en, ew, rv0, rv1;
            logic [15:0] ea, ed;
            boost = (prio == 1) && (mw != 0) && (m_wcnt[c] == mw);
            e0 = 0; e1 = 0;
            if (!rst) begin
                if (req0 && req1) begin
                    e1 = (prio == 1) ? boost : !m_last[c];
                    e0 = !e1;
                end else begin
                    e0 = req0; e1 = req1;
                end
            end
            en = e0 | e1;
            ew = e0 ? we0 : (e1 ? we1 : 1'b0);
            ea = e0 ? addr0 : (e1 ? addr1 : 16'h0);
            ed = e0 ? wdata0 : (e1 ? wdata1 : 16'h0);
            rv0 = !rst && m_pv[c] && !m_pid[c];
            rv1 = !rst && m_pv[c] && m_pid[c];
            chk("gnt0", c, 32'(o_gnt0[c]), 32'(e0));
            chk("gnt1", c, 32'(o_gnt1[c]), 32'(e1));
            chk("ram_en", c, 32'(o_en[c]), 32'(en));
            chk("ram_we", c, 32'(o_we[c]), 32'(ew));
            chk("ram_addr", c, 32'(o_addr[c]), 32'(ea));
            chk("ram_wdata", c, 32'(o_wd[c]), 32'(ed));
            chk("rvalid0", c, 32'(o_rv0[c]), 32'(rv0));
            chk("rvalid1", c, 32'(o_rv1[c]), 32'(rv1));
            chk("rdata0", c, 32'(o_rd0[c]), rv0 ? 32'(m_pdata[c]) : 32'h0);
            chk("rdata1", c, 32'(o_rd1[c]), rv1 ? 32'(m_pdata[c]) : 32'h0);
            if (rst) begin
                m_last[c] = 1; m_wcnt[c] = 0; m_pv[c] = 0; m_pid[c] = 0;
            end else begin
                m_pv[c]  = en && !ew;
                m_pid[c] = e1;
                if (en && !ew) m_pdata[c] = m_mem[c][ea[7:0]];
                if (en && ew) m_mem[c][ea[7:0]] = ed;
                if (en) m_last[c] = e1;
                if (prio == 1 && req1 && !e1) m_wcnt[c] = (m_wcnt[c] < mw) ? m_wcnt[c] + 1 : mw;
                else m_wcnt[c] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pat [8];
        for (int c = 0; c < 3; c++) begin
            m_last[c] = 1; m_wcnt[c] = 0; m_pv[c] = 0; m_pid[c] = 0; m_pdata[c] = 16'h0;
        end
        // reset held with both requesting, then idle
        rst = 1;
        drive(1, 0, 16'h0, 16'h0, 1, 0, 16'h0, 16'h0);
        cycle(); cycle();
        rst = 0; idle();
        cycle(); cycle();
        // CPU write then read-after-write
        drive(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0); cycle();
        drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);    cycle();
        idle(); cycle();
        // preload distinct data for each port's read address
        drive(1, 1, 16'h0020, 16'h1111, 0, 0, 16'h0, 16'h0); cycle();
        drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'h2222); cycle();
        // both ports read continuously: alternation / period-4 boost / no boost
        drive(1, 0, 16'h0020, 16'h0, 1, 0, 16'h0040, 16'h0);
        repeat (12) cycle();
        idle(); cycle();
        // port 1 denied twice, withdraws, then needs fresh denials
        pat = '{1, 1, 0, 1, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 16'h0020, 16'h0, pat[i], 0, 16'h0040, 16'h0);
            cycle();
        end
        idle(); cycle();
        // reset lands on the cycle after a port-1 read grant
        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0); cycle();
        idle(); rst = 1; cycle();
        rst = 0; cycle();
        drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0); cycle();
        idle(); cycle();
        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 255)), 16'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 255)), 16'($urandom));
            cycle();
        end
        rst = 0; idle(); cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
